dmem_access_ctrl: RTL and testbench

Sequencing controller for the data-RAM port in the MEM stage of the pipelined CPU. It takes the load/store intent from the pipeline and runs a req/ack handshake with a variable-latency, word-wide data RAM that has no byte enables. Sub-word stores (SB/SH) are done as read-modify-write. It produces sign/zero-extended load data for write-back and stalls the stage through `pipe_ready_go` until the access completes.

---
 rtl/dmem_access_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage controller for a word-wide, variable-latency
// data RAM without byte enables. Runs the req/ack handshake, turns SB/SH
// into read-modify-write, extends load data and stalls the stage until done.
module dmem_access_ctrl #(
    parameter int DATAW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             L_type,
    input  logic             S_type,
    input  logic [2:0]       func3,
    input  logic [DATAW-1:0] addr,
    input  logic [DATAW-1:0] st_data,
    input  logic             flush,
    input  logic             pipe_allowin,
    output logic             pipe_ready_go,
    output logic [DATAW-1:0] load_data,
    output logic             misalign_err,
    output logic             ram_req,
    output logic             ram_we,
    output logic [DATAW-1:0] ram_addr,
    output logic [DATAW-1:0] ram_wdata,
    input  logic [DATAW-1:0] ram_rdata,
    input  logic             ram_ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [DATAW-1:0] addr_q, addr_d;
    logic [2:0]       func3_q, func3_d;
    logic [15:0]      st_lane_q, st_lane_d;
    logic [DATAW-1:0] wdata_q, wdata_d;
    logic [DATAW-1:0] load_data_q, load_data_d;
    logic             is_load_q, is_load_d;
    logic             flushed_q, flushed_d;
    logic             mis_sticky_q, mis_sticky_d;

    logic             start_op;
    logic             misaligned;
    logic             is_word_in;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [DATAW-1:0] ext_data;
    logic [DATAW-1:0] merged;

    // Decode the incoming instruction: does it start a RAM op, and is it misaligned
    always_comb begin
        start_op   = valid_in & (L_type | S_type) & ~flush;
        is_word_in = (func3[1:0] == 2'b10);
        misaligned = ((func3[1:0] == 2'b01) & addr[0])
                   | (is_word_in & (addr[1:0] != 2'b00));
    end

    // Pick the addressed lane out of the returned word and extend it for write-back
    always_comb begin
        rd_byte = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
        rd_half = ram_rdata[{addr_q[1], 4'b0000} +: 16];
        case (func3_q)
            3'b000:  ext_data = {{(DATAW-8){rd_byte[7]}}, rd_byte};
            3'b100:  ext_data = {{(DATAW-8){1'b0}}, rd_byte};
            3'b001:  ext_data = {{(DATAW-16){rd_half[15]}}, rd_half};
            3'b101:  ext_data = {{(DATAW-16){1'b0}}, rd_half};
            default: ext_data = ram_rdata;
        endcase
    end

    // Overlay the store byte/half onto the word read back for a sub-word store
    always_comb begin
        merged = ram_rdata;
        if (func3_q[0] == 1'b0) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = st_lane_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = st_lane_q;
        end
    end

    // Next-state logic: FSM sequencing, operand latching and stage handshake
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        func3_d       = func3_q;
        st_lane_d     = st_lane_q;
        wdata_d       = wdata_q;
        load_data_d   = load_data_q;
        is_load_d     = is_load_q;
        flushed_d     = flushed_q;
        misalign_err  = 1'b0;
        pipe_ready_go = 1'b0;

        case (state_q)
            S_IDLE: begin
                pipe_ready_go = valid_in & ~(start_op & ~misaligned);
                if (start_op) begin
                    addr_d    = addr;
                    func3_d   = func3;
                    st_lane_d = st_data[15:0];
                    is_load_d = L_type;
                    if (!L_type) begin
                        wdata_d = st_data;
                    end
                    if (misaligned) begin
                        misalign_err = ~mis_sticky_q;
                    end else if (L_type || !is_word_in) begin
                        state_d = S_RD;
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_RD: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (ram_ack) begin
                    flushed_d = 1'b0;
                    if (flushed_q || flush) begin
                        state_d = S_IDLE;
                    end else if (is_load_q) begin
                        load_data_d = ext_data;
                        state_d     = S_DONE;
                    end else begin
                        wdata_d = merged;
                        state_d = S_WR;
                    end
                end
            end
            S_WR: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (ram_ack) begin
                    flushed_d = 1'b0;
                    state_d   = (flushed_q || flush) ? S_IDLE : S_DONE;
                end
            end
            default: begin
                pipe_ready_go = 1'b1;
                if (flush || pipe_allowin) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        mis_sticky_d = mis_sticky_q;
        if (!valid_in || flush || pipe_allowin) begin
            mis_sticky_d = 1'b0;
        end else if (misalign_err) begin
            mis_sticky_d = 1'b1;
        end
    end

    // RAM port is decoded from state and latched operands so it holds steady across a beat
    always_comb begin
        ram_req   = (state_q == S_RD) || (state_q == S_WR);
        ram_we    = (state_q == S_WR);
        ram_addr  = {addr_q[DATAW-1:2], 2'b00};
        ram_wdata = wdata_q;
        load_data = load_data_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            func3_q      <= '0;
            st_lane_q    <= '0;
            wdata_q      <= '0;
            load_data_q  <= '0;
            is_load_q    <= 1'b0;
            flushed_q    <= 1'b0;
            mis_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            func3_q      <= func3_d;
            st_lane_q    <= st_lane_d;
            wdata_q      <= wdata_d;
            load_data_q  <= load_data_d;
            is_load_q    <= is_load_d;
            flushed_q    <= flushed_d;
            mis_sticky_q <= mis_sticky_d;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed bench for dmem_access_ctrl with a RAM model
// that serves beats from an expected-beat scoreboard queue.
module tb_dmem_access_ctrl;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic        L_type = 1'b0;
    logic        S_type = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] st_data = 32'h0;
    logic        flush = 1'b0;
    logic        pipe_allowin = 1'b1;
    logic        pipe_ready_go;
    logic [31:0] load_data;
    logic        misalign_err;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic        ram_ack = 1'b0;

    beat_t exp_q[$];
    int    ram_wait = 0;
    int    wait_cnt = 0;
    int    beat_count = 0;
    int    check_count = 0;
    int    fail_count = 0;
    int    bc0;

    dmem_access_ctrl #(.DATAW(32)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .L_type(L_type), .S_type(S_type),
        .func3(func3), .addr(addr), .st_data(st_data), .flush(flush),
        .pipe_allowin(pipe_allowin), .pipe_ready_go(pipe_ready_go),
        .load_data(load_data), .misalign_err(misalign_err), .ram_req(ram_req),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic l, input logic s, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic fl, input logic al);
        valid_in     = v;
        L_type       = l;
        S_type       = s;
        func3        = f;
        addr         = a;
        st_data      = sd;
        flush        = fl;
        pipe_allowin = al;
    endtask

    task automatic pushBeat(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd);
        beat_t b;
        b.we    = we;
        b.addr  = a & 32'hFFFF_FFFC;
        b.wdata = wd;
        b.rdata = rd;
        exp_q.push_back(b);
    endtask

    // RAM model: acks after ram_wait request cycles and checks each beat against the queue
    always @(negedge clk) begin
        beat_t b;
        if (ram_req === 1'b1) begin
            if (wait_cnt >= ram_wait) begin
                ram_ack = 1'b1;
                beat_count++;
                wait_cnt = 0;
                if (exp_q.size() == 0) begin
                    check_count++;
                    fail_count++;
                    $error("[TB] FAIL unexpected_beat: observed we=%0b addr %h, expected no beat",
                           ram_we, ram_addr);
                end else begin
                    b = exp_q.pop_front();
                    checkOutput("beat_we", 32'(ram_we), 32'(b.we));
                    checkOutput("beat_addr", ram_addr, b.addr);
                    if (b.we) checkOutput("beat_wdata", ram_wdata, b.wdata);
                    ram_rdata = b.rdata;
                end
            end else begin
                ram_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            ram_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic doLoad(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] rd, input int wait_cycles, input logic [31:0] exp);
        int b0;
        b0 = beat_count;
        pushBeat(1'b0, a, 32'h0, rd);
        ram_wait = wait_cycles;
        @(negedge clk);
        applyStimulus(1, 1, 0, f, a, 32'h0, 0, 1);
        #1 checkOutput({tag, "_ready_c0"}, 32'(pipe_ready_go), 32'd0);
        for (int c = 1; c <= wait_cycles + 1; c++) begin
            @(negedge clk);
            #1 checkOutput({tag, "_ready_rd"}, 32'(pipe_ready_go), 32'd0);
            checkOutput({tag, "_req_rd"}, 32'(ram_req), 32'd1);
        end
        @(negedge clk);
        #1 checkOutput({tag, "_ready_done"}, 32'(pipe_ready_go), 32'd1);
        checkOutput({tag, "_load_data"}, load_data, exp);
        @(negedge clk);
        applyStimulus(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 1);
        #1 checkOutput({tag, "_req_idle"}, 32'(ram_req), 32'd0);
        checkOutput({tag, "_beats"}, 32'(beat_count - b0), 32'd1);
    endtask

    task automatic doStore(input string tag, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd,
                           input logic [31:0] exp_w, input int wait_cycles);
        int b0;
        int total;
        logic word;
        b0   = beat_count;
        word = (f[1:0] == 2'b10);
        if (!word) pushBeat(1'b0, a, 32'h0, rd);
        pushBeat(1'b1, a, exp_w, 32'h0);
        ram_wait = wait_cycles;
        total = word ? wait_cycles + 2 : 2 * wait_cycles + 3;
        @(negedge clk);
        applyStimulus(1, 0, 1, f, a, sd, 0, 1);
        #1 checkOutput({tag, "_ready_c0"}, 32'(pipe_ready_go), 32'd0);
        for (int c = 1; c < total; c++) begin
            @(negedge clk);
            #1 checkOutput({tag, "_ready_busy"}, 32'(pipe_ready_go), 32'd0);
            if (ram_we === 1'b1) checkOutput({tag, "_wdata"}, ram_wdata, exp_w);
        end
        @(negedge clk);
        #1 checkOutput({tag, "_ready_done"}, 32'(pipe_ready_go), 32'd1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 1);
        #1 checkOutput({tag, "_req_idle"}, 32'(ram_req), 32'd0);
        checkOutput({tag, "_beats"}, 32'(beat_count - b0), word ? 32'd1 : 32'd2);
    endtask

    // Directed sequence of scenarios
    initial begin
        applyStimulus(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 checkOutput("rst_req", 32'(ram_req), 32'd0);
        checkOutput("rst_we", 32'(ram_we), 32'd0);
        checkOutput("rst_addr", ram_addr, 32'h0);
        checkOutput("rst_wdata", ram_wdata, 32'h0);
        checkOutput("rst_load_data", load_data, 32'h0);
        checkOutput("rst_misalign", 32'(misalign_err), 32'd0);
        checkOutput("rst_ready", 32'(pipe_ready_go), 32'd0);

        $display("[TB] non-memory instruction");
        @(negedge clk);
        applyStimulus(1, 0, 0, 3'b000, 32'h1234, 32'h0, 0, 1);
        #1 checkOutput("nonmem_ready", 32'(pipe_ready_go), 32'd1);
        checkOutput("nonmem_req", 32'(ram_req), 32'd0);

        $display("[TB] loads");
        doLoad("lb", 3'b000, 32'h1003, 32'h80FF_1234, 2, 32'hFFFF_FF80);
        doLoad("lbu", 3'b100, 32'h1101, 32'h0000_F200, 0, 32'h0000_00F2);
        doLoad("lh", 3'b001, 32'h1102, 32'h8001_7FFF, 1, 32'hFFFF_8001);
        doLoad("lhu", 3'b101, 32'h1102, 32'h8001_7FFF, 0, 32'h0000_8001);
        doLoad("lh_low", 3'b001, 32'h1200, 32'h8001_7FFF, 0, 32'h0000_7FFF);

        $display("[TB] stores");
        doStore("sb", 3'b000, 32'h2001, 32'h0000_00AB, 32'h1122_3344, 32'h1122_AB44, 0);
        doStore("sh", 3'b001, 32'h2002, 32'h0000_CAFE, 32'h1122_3344, 32'hCAFE_3344, 1);
        doStore("sw", 3'b010, 32'h2004, 32'h5A5A_0F0F, 32'h0, 32'h5A5A_0F0F, 2);

        $display("[TB] misaligned LHU with downstream stall");
        bc0 = beat_count;
        @(negedge clk);
        applyStimulus(1, 1, 0, 3'b101, 32'h3001, 32'h0, 0, 0);
        #1 checkOutput("mis_pulse", 32'(misalign_err), 32'd1);
        checkOutput("mis_ready_c0", 32'(pipe_ready_go), 32'd1);
        checkOutput("mis_req_c0", 32'(ram_req), 32'd0);
        @(negedge clk);
        #1 checkOutput("mis_no_repulse", 32'(misalign_err), 32'd0);
        checkOutput("mis_ready_held", 32'(pipe_ready_go), 32'd1);
        checkOutput("mis_req_c1", 32'(ram_req), 32'd0);
        @(negedge clk);
        applyStimulus(1, 1, 0, 3'b101, 32'h3001, 32'h0, 0, 1);
        #1 checkOutput("mis_no_repulse_allow", 32'(misalign_err), 32'd0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 1);
        #1 checkOutput("mis_idle", 32'(misalign_err), 32'd0);
        checkOutput("mis_req_c3", 32'(ram_req), 32'd0);
        @(negedge clk);
        applyStimulus(1, 0, 1, 3'b010, 32'h3102, 32'h0, 0, 1);
        #1 checkOutput("mis_sw_pulse", 32'(misalign_err), 32'd1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 1);
        #1 checkOutput("mis_sw_idle", 32'(misalign_err), 32'd0);
        checkOutput("mis_beats", 32'(beat_count - bc0), 32'd0);

        $display("[TB] flush during SH read wait");
        bc0 = beat_count;
        pushBeat(1'b0, 32'h4002, 32'h0, 32'hAAAA_BBBB);
        ram_wait = 3;
        @(negedge clk);
        applyStimulus(1, 0, 1, 3'b001, 32'h4002, 32'h0000_5566, 0, 1);
        #1 checkOutput("fl_ready_c0", 32'(pipe_ready_go), 32'd0);
        @(negedge clk);
        applyStimulus(1, 0, 1, 3'b001, 32'h4002, 32'h0000_5566, 1, 1);
        #1 checkOutput("fl_req_c1", 32'(ram_req), 32'd1);
        checkOutput("fl_ready_c1", 32'(pipe_ready_go), 32'd0);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            applyStimulus(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 1);
            #1 checkOutput("fl_req_wait", 32'(ram_req), 32'd1);
            checkOutput("fl_we_wait", 32'(ram_we), 32'd0);
            checkOutput("fl_ready_wait", 32'(pipe_ready_go), 32'd0);
        end
        for (int c = 5; c <= 6; c++) begin
            @(negedge clk);
            #1 checkOutput("fl_req_after", 32'(ram_req), 32'd0);
            checkOutput("fl_ready_after", 32'(pipe_ready_go), 32'd0);
        end
        checkOutput("fl_beats", 32'(beat_count - bc0), 32'd1);

        $display("[TB] DONE stall on LW");
        bc0 = beat_count;
        pushBeat(1'b0, 32'h5004, 32'h0, 32'hDEAD_BEEF);
        ram_wait = 0;
        @(negedge clk);
        applyStimulus(1, 1, 0, 3'b010, 32'h5004, 32'h0, 0, 0);
        #1 checkOutput("st_ready_c0", 32'(pipe_ready_go), 32'd0);
        @(negedge clk);
        #1 checkOutput("st_req_c1", 32'(ram_req), 32'd1);
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            #1 checkOutput("st_ready_held", 32'(pipe_ready_go), 32'd1);
            checkOutput("st_load_data", load_data, 32'hDEAD_BEEF);
            checkOutput("st_no_req", 32'(ram_req), 32'd0);
        end
        @(negedge clk);
        applyStimulus(1, 1, 0, 3'b010, 32'h5004, 32'h0, 0, 1);
        #1 checkOutput("st_ready_release", 32'(pipe_ready_go), 32'd1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 1);
        #1 checkOutput("st_idle_ready", 32'(pipe_ready_go), 32'd0);
        checkOutput("st_idle_req", 32'(ram_req), 32'd0);
        checkOutput("st_beats", 32'(beat_count - bc0), 32'd1);

        $display("[TB] reset during SW write beat");
        pushBeat(1'b1, 32'h6008, 32'h1234_5678, 32'h0);
        ram_wait = 5;
        @(negedge clk);
        applyStimulus(1, 0, 1, 3'b010, 32'h6008, 32'h1234_5678, 0, 1);
        #1 checkOutput("rm_ready_c0", 32'(pipe_ready_go), 32'd0);
        @(negedge clk);
        #1 checkOutput("rm_req_wr", 32'(ram_req), 32'd1);
        checkOutput("rm_we_wr", 32'(ram_we), 32'd1);
        checkOutput("rm_wdata_wr", ram_wdata, 32'h1234_5678);
        @(negedge clk);
        rst = 1'b1;
        #1 checkOutput("rm_req_before_rst", 32'(ram_req), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 3'b000, 32'h0, 32'h0, 0, 1);
        exp_q.delete();
        #1 checkOutput("rm_req", 32'(ram_req), 32'd0);
        checkOutput("rm_we", 32'(ram_we), 32'd0);
        checkOutput("rm_addr", ram_addr, 32'h0);
        checkOutput("rm_wdata", ram_wdata, 32'h0);
        checkOutput("rm_load_data", load_data, 32'h0);
        checkOutput("rm_ready", 32'(pipe_ready_go), 32'd0);
        doLoad("lw_after_rst", 3'b010, 32'h7000, 32'h0BAD_F00D, 1, 32'h0BAD_F00D);

        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
